// File: rtl/tb_exit_periph.sv
// rtl/tb_exit_periph.sv - memory-mapped test-control responder (stdout FIFO, pass/fail, exit, cycle counter)
//
// Sits on an OBI-style data bus (req/gnt/rvalid) behind the subsystem decoder.
// Firmware writes stdout characters, test status and the exit code here; the
// block reports them to the testbench top and times out a hung program.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   data_req_i / data_gnt_o      bus request / grant (gnt combinational)
//   data_rvalid_o / data_rdata_o response, one cycle after each grant
//   data_addr_i [4:2]            register select
//   data_we_i, data_be_i         write enable, byte enables
//   data_wdata_i                 write data
//   char_valid_o / char_ready_i  stdout character stream handshake
//   char_data_o                  stdout FIFO head
//   tests_passed_o/failed_o      sticky pass / fail flags
//   exit_valid_o, exit_value_o   sticky exit flag, exit code
//   timeout_o                    sticky timeout flag
module tb_exit_periph #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789,
  parameter logic [31:0] FAIL_MAGIC = 32'd1,
  parameter logic [31:0] MAX_CYCLES = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic [7:0]  char_data_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        timeout_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] OFF_STDOUT = 3'd0;
  localparam logic [2:0] OFF_EXIT   = 3'd1;
  localparam logic [2:0] OFF_TEST   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CYCLES = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]    off;
  logic          stall;
  logic          gnt;
  logic          wr_acc;
  logic          push;
  logic          pop;
  logic          exit_wr;
  logic          test_wr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   cyc_q;
  logic [31:0]   rd_val;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic          passed_q, failed_q, timeout_q;
  logic [31:0]   exit_value_q;
  logic          unused_bits;

  assign unused_bits = ^{data_addr_i[31:5], data_addr_i[1:0], data_be_i[3:1]};

  assign off        = data_addr_i[4:2];
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Stall uses the registered full state only, so a pop in the same cycle
  // does not release the write until the following cycle.
  assign stall  = data_we_i && (off == OFF_STDOUT) && fifo_full;
  assign gnt    = data_req_i && !rst_i && !stall;
  assign wr_acc = gnt && data_we_i;

  assign push    = wr_acc && (off == OFF_STDOUT) && data_be_i[0];
  assign pop     = !fifo_empty && char_ready_i;
  assign exit_wr = wr_acc && (off == OFF_EXIT);
  assign test_wr = wr_acc && (off == OFF_TEST);

  // FIFO storage carries no reset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= data_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign char_valid_o = !fifo_empty;
  assign char_data_o  = fifo_empty ? 8'h00 : mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (exit_wr) state_d = ST_DRAIN;
      // A push this cycle means another character is still on its way.
      ST_DRAIN: if (fifo_empty && !push) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_value_q <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
    end else begin
      if (exit_wr && (state_q != ST_DONE)) exit_value_q <= data_wdata_i;
      if (test_wr && (data_wdata_i == PASS_MAGIC)) passed_q <= 1'b1;
      if (test_wr && (data_wdata_i == FAIL_MAGIC)) failed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
      if ((MAX_CYCLES != 32'd0) && (cyc_q == MAX_CYCLES - 32'd1) && (state_q != ST_DONE)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STATUS: rd_val = {16'b0, 8'(count_q), 5'b0, timeout_q, (state_q != ST_RUN), fifo_full};
      OFF_CYCLES: rd_val = cyc_q;
      default:    rd_val = '0;
    endcase
  end

  // One registered response per grant; rdata is zero unless it answers a read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      rdata_q  <= (gnt && !data_we_i) ? rd_val : 32'd0;
    end
  end

  assign data_gnt_o     = gnt;
  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rdata_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = (state_q == ST_DONE);
  assign exit_value_o   = exit_value_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_tb_exit_periph.sv
// tb/tb_tb_exit_periph.sv - scoreboard testbench for tb_exit_periph
//
// Stimulus drives directed bus transactions and pushes the expected response
// data and stdout characters into queues; a negedge monitor pops and compares
// whenever the DUT presents a response or a character handshake.
module tb_tb_exit_periph;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        char_valid_o;
  logic        char_ready_i = 1'b0;
  logic [7:0]  char_data_o;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;
  logic        timeout_o;

  localparam logic [31:0] A_STDOUT = 32'h00;
  localparam logic [31:0] A_EXIT   = 32'h04;
  localparam logic [31:0] A_TEST   = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h0C;
  localparam logic [31:0] A_CYCLES = 32'h10;
  localparam logic [31:0] A_UNMAP  = 32'h1C;

  int assertions = 0;
  int failures   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  char_q[$];
  logic [31:0] tb_cyc = '0;
  logic        prev_gnt = 1'b0;

  tb_exit_periph #(
    .FIFO_DEPTH(8),
    .PASS_MAGIC(32'd123456789),
    .FAIL_MAGIC(32'd1),
    .MAX_CYCLES(32'd100)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .data_req_i(data_req_i),
    .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i),
    .data_we_i(data_we_i),
    .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o),
    .char_valid_o(char_valid_o),
    .char_ready_i(char_ready_i),
    .char_data_o(char_data_o),
    .tests_passed_o(tests_passed_o),
    .tests_failed_o(tests_failed_o),
    .exit_valid_o(exit_valid_o),
    .exit_value_o(exit_value_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference cycle count: cleared by reset, +1 per edge, saturating.
  always @(posedge clk_i) begin
    if (rst_i) tb_cyc <= '0;
    else if (tb_cyc != 32'hFFFF_FFFF) tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: response ordering/timing and stdout character stream.
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      char_q.delete();
      prev_gnt = 1'b0;
    end else begin
      if (data_rvalid_o || prev_gnt) chk("rvalid_after_gnt", {31'b0, data_rvalid_o}, {31'b0, prev_gnt});
      if (data_rvalid_o) begin
        if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
        else chk("rdata", data_rdata_o, exp_q.pop_front());
      end
      if (char_valid_o && char_ready_i) begin
        if (char_q.size() == 0) chk("char_unexpected", {24'b0, char_data_o}, 32'hFFFF_FFFF);
        else chk("char_data", {24'b0, char_data_o}, {24'b0, char_q.pop_front()});
      end
      prev_gnt = data_gnt_o;
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1; data_req_i = 1'b0; char_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic bus_op(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] exp, input logic use_cyc);
    int waited;
    data_req_i = 1'b1; data_addr_i = addr; data_we_i = we; data_be_i = be; data_wdata_i = wdata;
    waited = 0;
    @(negedge clk_i);
    while (!data_gnt_o && waited < 50) begin
      waited++;
      @(negedge clk_i);
    end
    if (data_gnt_o) begin
      exp_q.push_back(use_cyc ? tb_cyc : exp);
      if (we && addr == A_STDOUT && be[0]) char_q.push_back(wdata[7:0]);
    end else begin
      chk("bus_grant_timeout", 32'd0, 32'd1);
    end
    @(posedge clk_i); #1;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0; data_addr_i = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    bus_op(addr, 1'b1, be, wdata, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus_op(addr, 1'b0, 4'hF, 32'd0, exp, 1'b0);
  endtask

  initial begin
    int n;

    // Exit with drain; timeout must stay clear once DONE
    do_reset();
    @(negedge clk_i);
    chk("reset_flags", {26'b0, data_gnt_o, data_rvalid_o, char_valid_o, tests_passed_o,
                        tests_failed_o, exit_valid_o}, 32'd0);
    chk("reset_exit_value", exit_value_o, 32'd0);
    chk("reset_timeout", {31'b0, timeout_o}, 32'd0);
    chk("reset_rdata", data_rdata_o, 32'd0);
    @(posedge clk_i); #1;
    for (int i = 0; i < 3; i++) wr(A_STDOUT, 32'h61 + i, 4'h1);
    wr(A_EXIT, 32'd5, 4'h0);
    repeat (3) @(negedge clk_i);
    chk("exit_hold_while_queued", {31'b0, exit_valid_o}, 32'd0);
    chk("exit_value_latched", exit_value_o, 32'd5);
    @(posedge clk_i); #1;
    rd(A_STATUS, 32'h0000_0302);
    char_ready_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (char_valid_o && n < 30) begin n++; @(negedge clk_i); end
    chk("drain_empty", {31'b0, char_valid_o}, 32'd0);
    chk("exit_not_early", {31'b0, exit_valid_o}, 32'd0);
    n = 0;
    while (!exit_valid_o && n < 3) begin n++; @(negedge clk_i); end
    chk("exit_valid_after_drain", {31'b0, exit_valid_o}, 32'd1);
    chk("exit_value_done", exit_value_o, 32'd5);
    @(posedge clk_i); #1;
    wr(A_EXIT, 32'd7, 4'hF);
    repeat (2) @(negedge clk_i);
    chk("exit_value_frozen", exit_value_o, 32'd5);
    @(posedge clk_i); #1;
    rd(A_STATUS, 32'h0000_0002);
    n = 0;
    while (tb_cyc < 32'd120 && n < 300) begin n++; @(negedge clk_i); end
    chk("no_timeout_after_exit", {31'b0, timeout_o}, 32'd0);
    @(posedge clk_i); #1;
    bus_op(A_CYCLES, 1'b0, 4'hF, 32'd0, 32'd0, 1'b1);

    // Timeout with no exit
    do_reset();
    n = 0;
    @(negedge clk_i);
    while (tb_cyc != 32'd99 && n < 200) begin n++; @(negedge clk_i); end
    chk("timeout_not_yet", {31'b0, timeout_o}, 32'd0);
    @(negedge clk_i);
    chk("timeout_set", {31'b0, timeout_o}, 32'd1);
    @(posedge clk_i); #1;
    rd(A_STATUS, 32'h0000_0004);
    bus_op(A_CYCLES, 1'b0, 4'hF, 32'd0, 32'd0, 1'b1);

    // Basic stdout with ready high, dropped write, unmapped read
    do_reset();
    char_ready_i = 1'b1;
    wr(A_STDOUT, 32'h48, 4'hF);
    wr(A_STDOUT, 32'h69, 4'h1);
    wr(A_STDOUT, 32'h55, 4'hE);
    rd(A_UNMAP, 32'd0);
    rd(A_STDOUT, 32'd0);
    repeat (4) @(negedge clk_i);
    chk("basic_chars_consumed", char_q.size(), 32'd0);
    chk("basic_fifo_empty", {31'b0, char_valid_o}, 32'd0);

    // Full FIFO stalls the ninth write
    @(posedge clk_i); #1;
    char_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_STDOUT, 32'h30 + i, 4'h1);
    rd(A_STATUS, 32'h0000_0801);
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = A_STDOUT; data_be_i = 4'h1; data_wdata_i = 32'h39;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("full_stall_gnt", {31'b0, data_gnt_o}, 32'd0);
    end
    @(posedge clk_i); #1 char_ready_i = 1'b1;
    @(negedge clk_i);
    chk("pop_same_cycle_still_stalled", {31'b0, data_gnt_o}, 32'd0);
    @(posedge clk_i); #1 char_ready_i = 1'b0;
    @(negedge clk_i);
    chk("stall_released", {31'b0, data_gnt_o}, 32'd1);
    if (data_gnt_o) begin
      exp_q.push_back(32'd0);
      char_q.push_back(8'h39);
    end
    @(posedge clk_i); #1;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
    char_ready_i = 1'b1;
    repeat (12) @(negedge clk_i);
    chk("full_chars_consumed", char_q.size(), 32'd0);

    // Pass / fail flags
    @(posedge clk_i); #1;
    char_ready_i = 1'b0;
    wr(A_TEST, 32'd123456789, 4'hF);
    @(negedge clk_i);
    chk("passed_set", {31'b0, tests_passed_o}, 32'd1);
    chk("failed_clear", {31'b0, tests_failed_o}, 32'd0);
    @(posedge clk_i); #1;
    wr(A_TEST, 32'd42, 4'hF);
    @(negedge clk_i);
    chk("other_value_ignored", {30'b0, tests_passed_o, tests_failed_o}, 32'd2);
    @(posedge clk_i); #1;
    wr(A_TEST, 32'd1, 4'hF);
    @(negedge clk_i);
    chk("both_flags", {30'b0, tests_passed_o, tests_failed_o}, 32'd3);

    // Reset during DRAIN
    @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) wr(A_STDOUT, 32'h70 + i, 4'h1);
    wr(A_EXIT, 32'd9, 4'hF);
    @(negedge clk_i);
    chk("drain_exit_value", exit_value_o, 32'd9);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("mid_reset_flags", {26'b0, data_rvalid_o, char_valid_o, tests_passed_o, tests_failed_o,
                            exit_valid_o, timeout_o}, 32'd0);
    chk("mid_reset_exit_value", exit_value_o, 32'd0);
    chk("mid_reset_char_data", {24'b0, char_data_o}, 32'd0);
    @(posedge clk_i); #1;
    char_ready_i = 1'b1;
    wr(A_STDOUT, 32'h41, 4'h1);
    repeat (4) @(negedge clk_i);
    chk("post_reset_char_consumed", char_q.size(), 32'd0);
    chk("post_reset_no_exit", {31'b0, exit_valid_o}, 32'd0);
    chk("responses_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/tb_exit_periph.md
Name: tb_exit_periph

Overview:
- Memory-mapped test-control responder in the core testbench subsystem. It sits on the core data bus (OBI-style req/gnt/rvalid) behind the subsystem address decoder.
- It receives firmware writes for stdout characters, test pass/fail and program exit, and drives the tests_passed/tests_failed/exit_valid/exit_value status consumed by the testbench top.
- It buffers stdout characters in a FIFO drained by a character sink, and provides a free-running cycle counter with an optional timeout.

Parameters:
- FIFO_DEPTH, 8, stdout FIFO entries; power of two, >=2.
- PASS_MAGIC, 32'd123456789, TEST_STATUS write value that sets tests_passed_o.
- FAIL_MAGIC, 32'd1, TEST_STATUS write value that sets tests_failed_o.
- MAX_CYCLES, 0, timeout threshold in cycles; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- data_req_i  in  1  bus request (address already decoded to this block).
- data_gnt_o  out  1  grant.
- data_rvalid_o  out  1  response valid.
- data_addr_i  in  32  byte address; only [4:2] used.
- data_we_i  in  1  write enable.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data.
- char_valid_o  out  1  stdout character available.
- char_ready_i  in  1  sink accepts the character.
- char_data_o  out  8  FIFO head character.
- tests_passed_o  out  1  sticky pass flag.
- tests_failed_o  out  1  sticky fail flag.
- exit_valid_o  out  1  sticky exit flag.
- exit_value_o  out  32  exit code.
- timeout_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i high at a clk_i edge): all outputs 0, FIFO empty, cycle counter 0, FSM in RUN. Reset mid-operation discards the FIFO contents and any pending response.
- Register map (offset = addr[4:2]*4):
  - 0x00 STDOUT W: push wdata[7:0] if be[0]; otherwise the write is accepted and dropped.
  - 0x04 EXIT W: latch the full wdata (be ignored) into exit_value_o.
  - 0x08 TEST_STATUS W: ==PASS_MAGIC sets tests_passed_o; ==FAIL_MAGIC sets tests_failed_o; any other value is ignored.
  - 0x0C STATUS R: {16'b0, fifo_count[7:0], 5'b0, timeout, exiting, fifo_full}.
  - 0x10 CYCLES R: cycle counter.
  - All other offsets: reads return 0; writes are ignored.
- Handshake:
  - data_gnt_o = data_req_i combinationally, except a STDOUT write while the FIFO is full (registered full state) gets gnt=0. A pop in the same cycle does not un-stall; the write is granted the next cycle.
  - data_rvalid_o is asserted exactly one cycle after each grant, for exactly one cycle. data_rdata_o is valid with rvalid; it is 0 for writes and 0 when rvalid is low.
  - Back-to-back grants are supported: one response per grant, in order.
- FIFO:
  - Push on a granted STDOUT write with be[0]. Pop when char_valid_o && char_ready_i.
  - char_valid_o = !empty; char_data_o = head. Push into empty makes char_valid_o high the next cycle.
  - Simultaneous push and pop when not full leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Exit FSM:
  - RUN: an EXIT write latches the value and moves to DRAIN.
  - DRAIN: STDOUT writes are still accepted. Move to DONE on the first cycle the FIFO is empty with no push in that cycle.
  - DONE: exit_valid_o=1 (registered, asserted the cycle after the DRAIN->DONE decision). Further EXIT writes are granted but ignored; exit_value_o is frozen.
  - A second EXIT write in DRAIN overwrites the value.
- Pass/fail flags: sticky until reset; both may be set. Each is set the cycle after the granted write.
- Cycle counter:
  - 32-bit, increments every cycle after reset; saturates at 32'hFFFFFFFF (no wrap).
  - If MAX_CYCLES != 0 and counter == MAX_CYCLES-1 while not in DONE, timeout_o is set the next cycle (sticky). The timeout does not affect the bus or the FIFO.

Test Plan:
- Reset, then write 0x48 ('H'), 0x69 to STDOUT with char_ready_i=1 -> char_data_o emits 0x48 then 0x69, each rvalid one cycle after its gnt, rdata 0.
- char_ready_i=0 with FIFO_DEPTH=8; 9 STDOUT writes -> 8 granted, 9th has gnt=0 until char_ready_i pulses once; STATUS read shows fifo_count=8, full=1 beforehand.
- char_ready_i=0; 3 chars pushed; EXIT write 0x5 -> exit_valid_o stays 0; raise ready -> exit_valid_o=1 the cycle after the 3rd pop; exit_value_o=5; a later EXIT write of 7 leaves the value at 5.
- TEST_STATUS writes of 123456789, then 42 -> tests_passed_o=1 one cycle after the first write, tests_failed_o stays 0; a write of 1 -> tests_failed_o=1, passed still 1.
- MAX_CYCLES=100, no EXIT write -> timeout_o rises after cycle 100; with EXIT completed at cycle 50, timeout_o stays 0; CYCLES read returns the current count.
- Assert rst_i during DRAIN with 4 chars queued -> next cycle all outputs 0 and char_valid_o=0; a new STDOUT write works normally.
